// File: rtl/timing_gen_pkg.sv
// Shared types and constants for the MCS-4 timing generator: subcycle and
// segment codes, default segment lengths, and the countdown width helper.
package mcs4_pkg;

    // Instruction-cycle subcycles, A1 first
    typedef enum logic [2:0] {
        SC_A1 = 3'd0,
        SC_A2 = 3'd1,
        SC_A3 = 3'd2,
        SC_M1 = 3'd3,
        SC_M2 = 3'd4,
        SC_X1 = 3'd5,
        SC_X2 = 3'd6,
        SC_X3 = 3'd7
    } subcycle_e;

    // Segments within one subcycle, in the order they occur
    typedef enum logic [1:0] {
        SEG_CLK1 = 2'd0,
        SEG_GAP1 = 2'd1,
        SEG_CLK2 = 2'd2,
        SEG_GAP2 = 2'd3
    } segment_e;

    localparam int T_CLK1_DEF  = 20;
    localparam int T_CLK2_DEF  = 20;
    localparam int T_GAP_DEF   = 14;
    localparam int SUBCYCLE_W  = 3;
    localparam int SEGMENT_W   = 2;
    localparam int NUM_SUBCYC  = 8;

    // Countdown width: must hold the largest segment length itself, so a
    // power-of-two length still fits (hence the +1).
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/timing_gen_if.sv
// Timing bus from the generator (master) to the scratchpad, decode and bus
// logic (slave): two-phase clocks, subcycle strobes, latch strobe and sync.
interface timing_gen_if;
    logic clk1;
    logic clk2;
    logic a12;
    logic a22;
    logic a32;
    logic m12;
    logic m22;
    logic x12;
    logic x22;
    logic x32;
    logic m12_m22_clk1_m11_m12;
    logic sync;

    modport master (
        output clk1, clk2, a12, a22, a32, m12, m22, x12, x22, x32,
        output m12_m22_clk1_m11_m12, sync
    );

    modport slave (
        input clk1, clk2, a12, a22, a32, m12, m22, x12, x22, x32,
        input m12_m22_clk1_m11_m12, sync
    );
endinterface

// File: rtl/timing_gen_clk_phase.sv
// Segment sequencer for one subcycle (CLK1, GAP1, CLK2, GAP2) and the
// registered two-phase clock decode. Pulses subcycle_adv on the edge that
// leaves GAP2; 'hold' parks the sequencer at the end of GAP2.
module clk_phase
    import mcs4_pkg::*;
#(
    parameter int T_CLK1 = T_CLK1_DEF,
    parameter int T_CLK2 = T_CLK2_DEF,
    parameter int T_GAP  = T_GAP_DEF
) (
    input  logic clk,
    input  logic srst,
    input  logic hold,
    output logic clk1,
    output logic clk2,
    output logic clk1_rise,
    output logic clk2_rise,
    output logic subcycle_adv
);

    localparam int CNT_W = cnt_width(T_CLK1, T_CLK2, T_GAP);
    localparam logic [CNT_W-1:0] LD_CLK1 = CNT_W'(T_CLK1);
    localparam logic [CNT_W-1:0] LD_CLK2 = CNT_W'(T_CLK2);
    localparam logic [CNT_W-1:0] LD_GAP  = CNT_W'(T_GAP);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    segment_e         seg_q, seg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk1_q, clk1_d;
    logic             clk2_q, clk2_d;

    // Next segment/countdown; clocks are a one-edge-late decode of the segment
    always_comb begin
        seg_d        = seg_q;
        cnt_d        = cnt_q - ONE;
        clk1_d       = (seg_q == SEG_CLK1);
        clk2_d       = (seg_q == SEG_CLK2);
        subcycle_adv = 1'b0;
        if (cnt_q == ONE) begin
            case (seg_q)
                SEG_CLK1: begin
                    seg_d = SEG_GAP1;
                    cnt_d = LD_GAP;
                end
                SEG_GAP1: begin
                    seg_d = SEG_CLK2;
                    cnt_d = LD_CLK2;
                end
                SEG_CLK2: begin
                    seg_d = SEG_GAP2;
                    cnt_d = LD_GAP;
                end
                default: begin
                    if (hold) begin
                        cnt_d = cnt_q;
                    end else begin
                        seg_d        = SEG_CLK1;
                        cnt_d        = LD_CLK1;
                        subcycle_adv = 1'b1;
                    end
                end
            endcase
        end
    end

    // Segment state and clock registers
    always_ff @(posedge clk) begin
        if (srst) begin
            seg_q  <= SEG_CLK1;
            cnt_q  <= LD_CLK1;
            clk1_q <= 1'b0;
            clk2_q <= 1'b0;
        end else begin
            seg_q  <= seg_d;
            cnt_q  <= cnt_d;
            clk1_q <= clk1_d;
            clk2_q <= clk2_d;
        end
    end

    assign clk1      = clk1_q;
    assign clk2      = clk2_q;
    // True on the edge where the registered clock goes high
    assign clk1_rise = (seg_q == SEG_CLK1) & ~clk1_q;
    assign clk2_rise = (seg_q == SEG_CLK2) & ~clk2_q;

endmodule

// File: rtl/timing_gen.sv
// MCS-4 4004 timing generator: two-phase clocks, A1..X3 subcycle strobes,
// data-in latch strobe and sync. Optional macro TIMING_SINGLE_STEP_EN adds
// halt/step inputs that park the machine at the end of X3.
module timing_gen
    import mcs4_pkg::*;
#(
    parameter int T_CLK1 = T_CLK1_DEF,
    parameter int T_CLK2 = T_CLK2_DEF,
    parameter int T_GAP  = T_GAP_DEF
) (
    input  logic         sysclk,
    input  logic         poc,
`ifdef TIMING_SINGLE_STEP_EN
    input  logic         halt,
    input  logic         step,
`endif
    timing_gen_if.master tif
);

    logic      clk1, clk2, clk1_rise, clk2_rise, subcycle_adv, hold;
    subcycle_e sub_q, sub_d;
    logic [NUM_SUBCYC-1:0] strobe_q, strobe_d;
    logic      m11_q, m11_d;
    logic      sync_q, sync_d;

`ifdef TIMING_SINGLE_STEP_EN
    // Park at the X3 -> A1 boundary while halted; a step pulse lets one cycle go
    assign hold = halt & (sub_q == SC_X3) & ~step;
`else
    assign hold = 1'b0;
`endif

    clk_phase #(
        .T_CLK1 (T_CLK1),
        .T_CLK2 (T_CLK2),
        .T_GAP  (T_GAP)
    ) u_clk_phase (
        .clk          (sysclk),
        .srst         (poc),
        .hold         (hold),
        .clk1         (clk1),
        .clk2         (clk2),
        .clk1_rise    (clk1_rise),
        .clk2_rise    (clk2_rise),
        .subcycle_adv (subcycle_adv)
    );

    // Subcycle advance; strobes move on clk2 rise, m11/sync on clk1 rise
    always_comb begin
        sub_d    = sub_q;
        strobe_d = strobe_q;
        m11_d    = m11_q;
        sync_d   = sync_q;
        if (subcycle_adv) begin
            sub_d = subcycle_e'(sub_q + 3'd1);
        end
        if (clk2_rise) begin
            strobe_d = NUM_SUBCYC'(1) << sub_q;
        end
        if (clk1_rise) begin
            m11_d  = (sub_q == SC_M1);
            sync_d = (sub_q == SC_X3);
        end
    end

    // Subcycle counter and phase history
    always_ff @(posedge sysclk) begin
        if (poc) begin
            sub_q    <= SC_A1;
            strobe_q <= '0;
            m11_q    <= 1'b0;
            sync_q   <= 1'b0;
        end else begin
            sub_q    <= sub_d;
            strobe_q <= strobe_d;
            m11_q    <= m11_d;
            sync_q   <= sync_d;
        end
    end

    assign tif.clk1 = clk1;
    assign tif.clk2 = clk2;
    assign tif.a12  = strobe_q[SC_A1];
    assign tif.a22  = strobe_q[SC_A2];
    assign tif.a32  = strobe_q[SC_A3];
    assign tif.m12  = strobe_q[SC_M1];
    assign tif.m22  = strobe_q[SC_M2];
    assign tif.x12  = strobe_q[SC_X1];
    assign tif.x22  = strobe_q[SC_X2];
    assign tif.x32  = strobe_q[SC_X3];
    // Latch open across M12..M22, plus clk1 pulses outside the M11..M12 window
    assign tif.m12_m22_clk1_m11_m12 = strobe_q[SC_M1] | strobe_q[SC_M2]
                                    | (clk1 & ~(m11_q | strobe_q[SC_M1]));
    assign tif.sync = sync_q;

endmodule
